// File: rtl/dispatch_queue_if.sv
// Decode-to-dispatcher enqueue bus and dispatcher-to-unit handshake bus.
// Signal names are seen from the dispatcher, which uses the slave modport.
interface dispatch_queue_if #(
   parameter int NUM_FU    = 5,
   parameter int DATA_W    = 32,
   parameter int PAYLOAD_W = 64
);
   logic                 i_valid;
   logic                 o_ready;
   logic [NUM_FU-1:0]    i_fu_sel;
   logic [1:0]           i_opa_sel;
   logic [1:0]           i_opb_sel;
   logic [DATA_W-1:0]    i_rs1_data;
   logic [DATA_W-1:0]    i_rs2_data;
   logic [DATA_W-1:0]    i_pc;
   logic [DATA_W-1:0]    i_imm;
   logic [PAYLOAD_W-1:0] i_payload;
   logic [NUM_FU-1:0]    o_fu_valid;
   logic [NUM_FU-1:0]    i_fu_ready;
   logic [DATA_W-1:0]    o_opa;
   logic [DATA_W-1:0]    o_opb;
   logic [DATA_W-1:0]    o_rs2;
   logic [PAYLOAD_W-1:0] o_payload;

   modport slave (
      input  i_valid, i_fu_sel, i_opa_sel, i_opb_sel, i_rs1_data, i_rs2_data,
             i_pc, i_imm, i_payload, i_fu_ready,
      output o_ready, o_fu_valid, o_opa, o_opb, o_rs2, o_payload
   );

   modport master (
      output i_valid, i_fu_sel, i_opa_sel, i_opb_sel, i_rs1_data, i_rs2_data,
             i_pc, i_imm, i_payload, i_fu_ready,
      input  o_ready, o_fu_valid, o_opa, o_opb, o_rs2, o_payload
   );
endinterface

// File: rtl/dispatch_queue.sv
// In-order dispatch FIFO: muxes operands at enqueue, presents the head to one
// functional unit, with flush, illegal-target drop and stall accounting.
module dispatch_queue #(
   parameter int NUM_FU    = 5,
   parameter int DEPTH     = 4,
   parameter int DATA_W    = 32,
   parameter int PAYLOAD_W = 64
) (
   input  logic                      i_clk,
   input  logic                      i_rst_n,
   input  logic                      i_flush,
   dispatch_queue_if.slave           bus,
   output logic [$clog2(DEPTH):0]    o_count,
   output logic                      o_illegal,
   output logic [31:0]               o_stall_cnt
);
   localparam int AW = $clog2(DEPTH);

   logic [DATA_W-1:0]    r_opa_mem [DEPTH];
   logic [DATA_W-1:0]    r_opb_mem [DEPTH];
   logic [DATA_W-1:0]    r_rs2_mem [DEPTH];
   logic [PAYLOAD_W-1:0] r_pay_mem [DEPTH];
   logic [NUM_FU-1:0]    r_sel_mem [DEPTH];

   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;
   logic [31:0]   r_stall_cnt;

   logic [DATA_W-1:0] w_opa;
   logic [DATA_W-1:0] w_opb;
   logic [NUM_FU-1:0] w_head_sel;
   logic [NUM_FU-1:0] w_sel_low;
   logic              w_head_valid;
   logic              w_zero_hot;
   logic              w_accept;
   logic              w_enq;
   logic              w_deq;
   logic              w_stall;

   always_comb begin
      w_opa = '0;
      w_opb = '0;
      if (!bus.i_opa_sel[1]) w_opa = bus.i_opa_sel[0] ? bus.i_pc  : bus.i_rs1_data;
      if (!bus.i_opb_sel[1]) w_opb = bus.i_opb_sel[0] ? bus.i_imm : bus.i_rs2_data;
   end

   assign w_head_valid = (r_count != '0);
   assign w_head_sel   = r_sel_mem[r_rd_ptr];
   // x & -x isolates the lowest set bit, so multi-hot targets only the lowest unit
   assign w_sel_low    = w_head_sel & (~w_head_sel + NUM_FU'(1));
   assign w_zero_hot   = w_head_valid && (w_head_sel == '0);

   assign bus.o_ready    = (r_count != (AW+1)'(DEPTH));
   assign bus.o_fu_valid = (w_head_valid && !i_flush) ? w_sel_low : '0;
   assign bus.o_opa      = r_opa_mem[r_rd_ptr];
   assign bus.o_opb      = r_opb_mem[r_rd_ptr];
   assign bus.o_rs2      = r_rs2_mem[r_rd_ptr];
   assign bus.o_payload  = r_pay_mem[r_rd_ptr];

   assign w_accept = |(bus.o_fu_valid & bus.i_fu_ready);
   assign w_enq    = bus.i_valid && bus.o_ready && !i_flush;
   assign w_deq    = !i_flush && (w_zero_hot || w_accept);
   assign w_stall  = w_head_valid && !i_flush && !w_zero_hot && !w_accept;

   assign o_count     = r_count;
   assign o_illegal   = w_zero_hot && !i_flush;
   assign o_stall_cnt = r_stall_cnt;

   always_ff @(posedge i_clk) begin
      if (w_enq) begin
         r_opa_mem[r_wr_ptr] <= w_opa;
         r_opb_mem[r_wr_ptr] <= w_opb;
         r_rs2_mem[r_wr_ptr] <= bus.i_rs2_data;
         r_pay_mem[r_wr_ptr] <= bus.i_payload;
         r_sel_mem[r_wr_ptr] <= bus.i_fu_sel;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_wr_ptr    <= '0;
         r_rd_ptr    <= '0;
         r_count     <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_deq) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_enq, w_deq})
               2'b10:   r_count <= r_count + (AW+1)'(1);
               2'b01:   r_count <= r_count - (AW+1)'(1);
               default: r_count <= r_count;
            endcase
         end
         if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end
endmodule

// File: tb/tb_dispatch_queue.sv
// Directed bench for dispatch_queue with hand-computed expectations.
module tb_dispatch_queue;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic [2:0]  count;
   logic        illegal;
   logic [31:0] stall_cnt;
   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   dispatch_queue_if #(.NUM_FU(5), .DATA_W(32), .PAYLOAD_W(64)) bus ();

   dispatch_queue #(.NUM_FU(5), .DEPTH(4), .DATA_W(32), .PAYLOAD_W(64)) u_dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_flush     (flush),
      .bus         (bus.slave),
      .o_count     (count),
      .o_illegal   (illegal),
      .o_stall_cnt (stall_cnt)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [4:0] sel, input logic [1:0] asel, input logic [1:0] bsel,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [31:0] pc,
                        input logic [31:0] imm, input logic [63:0] pay);
      bus.i_valid    = 1'b1;
      bus.i_fu_sel   = sel;
      bus.i_opa_sel  = asel;
      bus.i_opb_sel  = bsel;
      bus.i_rs1_data = rs1;
      bus.i_rs2_data = rs2;
      bus.i_pc       = pc;
      bus.i_imm      = imm;
      bus.i_payload  = pay;
   endtask

   initial begin
      rst_n = 1'b0;
      flush = 1'b0;
      bus.i_fu_ready = '1;
      drive(5'b0, 2'b00, 2'b00, '0, '0, '0, '0, '0);
      bus.i_valid = 1'b0;
      step();
      step();
      check("rst_count", 64'(count), 64'd0);
      check("rst_fu_valid", 64'(bus.o_fu_valid), 64'd0);
      check("rst_illegal", 64'(illegal), 64'd0);
      check("rst_stall", 64'(stall_cnt), 64'd0);
      rst_n = 1'b1;
      step();
      check("rst_ready", 64'(bus.o_ready), 64'd1);

      // basic ALU dispatch
      drive(5'b00001, 2'b00, 2'b01, 32'h10, 32'h3, 32'h0, 32'h5, 64'hA1);
      step();
      bus.i_valid = 1'b0;
      check("basic_valid", 64'(bus.o_fu_valid), 64'h01);
      check("basic_opa", 64'(bus.o_opa), 64'h10);
      check("basic_opb", 64'(bus.o_opb), 64'h5);
      check("basic_pay", bus.o_payload, 64'hA1);
      check("basic_count", 64'(count), 64'd1);
      step();
      check("basic_drain", 64'(count), 64'd0);
      check("basic_idle", 64'(bus.o_fu_valid), 64'd0);

      // LUI / AUIPC style operand selection
      drive(5'b00010, 2'b10, 2'b01, 32'hDEAD, 32'h77, 32'h400, 32'h12345000, 64'hB2);
      step();
      bus.i_valid = 1'b0;
      check("lui_opa", 64'(bus.o_opa), 64'h0);
      check("lui_opb", 64'(bus.o_opb), 64'h12345000);
      check("lui_valid", 64'(bus.o_fu_valid), 64'h02);
      step();
      drive(5'b00010, 2'b01, 2'b10, 32'hDEAD, 32'h77, 32'h400, 32'h12345000, 64'hB3);
      step();
      bus.i_valid = 1'b0;
      check("auipc_opa", 64'(bus.o_opa), 64'h400);
      check("zero_opb", 64'(bus.o_opb), 64'h0);
      check("raw_rs2", 64'(bus.o_rs2), 64'h77);
      step();

      // back-pressure on MUL
      bus.i_fu_ready = 5'b10111;
      for (int i = 0; i < 4; i++) begin
         drive(5'b01000, 2'b00, 2'b00, 32'(i + 1), 32'h0, 32'h0, 32'h0, 64'(100 + i));
         step();
      end
      check("bp_full_count", 64'(count), 64'd4);
      check("bp_not_ready", 64'(bus.o_ready), 64'd0);
      check("bp_stall3", 64'(stall_cnt), 64'd3);
      drive(5'b01000, 2'b00, 2'b00, 32'h99, 32'h0, 32'h0, 32'h0, 64'h99);
      step();
      bus.i_valid = 1'b0;
      check("bp_5th_rejected", 64'(count), 64'd4);
      check("bp_head_stable", 64'(bus.o_opa), 64'd1);
      check("bp_head_valid", 64'(bus.o_fu_valid), 64'h08);
      step();
      check("bp_stall5", 64'(stall_cnt), 64'd5);
      bus.i_fu_ready = '1;
      for (int i = 0; i < 4; i++) begin
         check("bp_drain_opa", 64'(bus.o_opa), 64'(i + 1));
         check("bp_drain_pay", bus.o_payload, 64'(100 + i));
         step();
      end
      check("bp_empty", 64'(count), 64'd0);
      check("bp_stall_hold", 64'(stall_cnt), 64'd5);

      // streaming across pointer wrap
      for (int j = 0; j < 10; j++) begin
         drive(5'b00100, 2'b00, 2'b00, 32'(32'h200 + j), 32'h0, 32'h0, 32'h0, 64'(j));
         step();
         check("wrap_opa", 64'(bus.o_opa), 64'(32'h200 + j));
         check("wrap_pay", bus.o_payload, 64'(j));
         check("wrap_count", 64'(count), 64'd1);
      end
      bus.i_valid = 1'b0;
      step();
      check("wrap_empty", 64'(count), 64'd0);

      // flush with an in-flight instruction
      bus.i_fu_ready = '0;
      for (int i = 0; i < 3; i++) begin
         drive(5'b00001, 2'b00, 2'b00, 32'(i), 32'h0, 32'h0, 32'h0, 64'(i));
         step();
      end
      check("fl_count3", 64'(count), 64'd3);
      flush = 1'b1;
      drive(5'b00001, 2'b00, 2'b00, 32'h55, 32'h0, 32'h0, 32'h0, 64'h55);
      #1;
      check("fl_valid_low", 64'(bus.o_fu_valid), 64'd0);
      step();
      flush = 1'b0;
      bus.i_valid = 1'b0;
      check("fl_count0", 64'(count), 64'd0);
      check("fl_stall_kept", 64'(stall_cnt), 64'd7);
      step();
      check("fl_not_enq", 64'(count), 64'd0);

      // zero-hot target
      bus.i_fu_ready = '1;
      drive(5'b00000, 2'b00, 2'b00, 32'h1, 32'h0, 32'h0, 32'h0, 64'h1);
      step();
      bus.i_valid = 1'b0;
      check("ill_pulse", 64'(illegal), 64'd1);
      check("ill_no_valid", 64'(bus.o_fu_valid), 64'd0);
      step();
      check("ill_dropped", 64'(count), 64'd0);
      check("ill_once", 64'(illegal), 64'd0);

      // multi-hot target, non-targeted ready ignored
      bus.i_fu_ready = 5'b11011;
      drive(5'b10100, 2'b00, 2'b00, 32'h2, 32'h0, 32'h0, 32'h0, 64'h2);
      step();
      bus.i_valid = 1'b0;
      check("mh_lowest", 64'(bus.o_fu_valid), 64'h04);
      step();
      check("mh_held", 64'(count), 64'd1);
      check("mh_stall", 64'(stall_cnt), 64'd8);
      bus.i_fu_ready = '1;
      step();
      check("mh_drain", 64'(count), 64'd0);

      // reset mid-operation
      bus.i_fu_ready = '0;
      for (int i = 0; i < 2; i++) begin
         drive(5'b00010, 2'b00, 2'b00, 32'(i), 32'h0, 32'h0, 32'h0, 64'(i));
         step();
      end
      bus.i_valid = 1'b0;
      check("mr_count", 64'(count), 64'd2);
      check("mr_stall", 64'(stall_cnt), 64'd9);
      rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      check("mr_cleared", 64'(count), 64'd0);
      check("mr_stall_clr", 64'(stall_cnt), 64'd0);
      check("mr_valid", 64'(bus.o_fu_valid), 64'd0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
